// File: rtl/swap_pkg.sv
// Shared encodings for the register-file swap controller.
package swap_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_MOVE  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    localparam logic MODE_SWAP = 1'b0;
    localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/swap_regfile.sv
// Async-clear register array: one write port, two combinational read ports.
// Out-of-range read addresses return zero; callers keep write addresses in range.
module swap_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr0_i,
    output logic [WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = (32'(raddr0_i) < DEPTH) ? mem_q[raddr0_i] : '0;
    assign rdata1_o = (32'(raddr1_i) < DEPTH) ? mem_q[raddr1_i] : '0;

endmodule

// File: rtl/swap_ctrl_rf.sv
// Register-file swapper: swaps or copies two entries through a temp register
// using an IDLE/LOAD/MOVE/STORE sequence, with a host write/read port.
module swap_ctrl_rf
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_rej,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [AW-1:0]    a_q, a_d;
    logic [AW-1:0]    b_q, b_d;
    logic [WIDTH-1:0] temp_q, temp_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;
    logic             wr_rej_q, wr_rej_d;

    logic             idle;
    logic             a_ok, b_ok, wr_ok;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    int_raddr;
    logic [WIDTH-1:0] int_rdata;

    assign idle  = (state_q == S_IDLE);
    assign a_ok  = 32'(addr_a) < DEPTH;
    assign b_ok  = 32'(addr_b) < DEPTH;
    assign wr_ok = 32'(wr_addr) < DEPTH;

    // LOAD fetches the source entry; MOVE fetches the destination entry.
    assign int_raddr = (state_q == S_LOAD) ? a_q : b_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        a_d       = a_q;
        b_d       = b_q;
        temp_d    = temp_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (a_ok && b_ok) begin
                        mode_d  = mode;
                        a_d     = addr_a;
                        b_d     = addr_b;
                        state_d = S_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                temp_d  = int_rdata;
                state_d = (mode_q == MODE_COPY) ? S_STORE : S_MOVE;
            end
            S_MOVE: state_d = S_STORE;
            S_STORE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Host writes only reach the array in IDLE, so the FSM never contends for the port.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        case (state_q)
            S_IDLE: rf_we = wr_en && wr_ok;
            S_MOVE: begin
                rf_we    = 1'b1;
                rf_waddr = a_q;
                rf_wdata = int_rdata;
            end
            S_STORE: begin
                rf_we    = 1'b1;
                rf_waddr = b_q;
                rf_wdata = temp_q;
            end
            default: rf_we = 1'b0;
        endcase
    end

    assign wr_rej_d = wr_en && (!idle || !wr_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_SWAP;
            a_q       <= '0;
            b_q       <= '0;
            temp_q    <= '0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            wr_rej_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            temp_q    <= temp_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
            wr_rej_q  <= wr_rej_d;
        end
    end

    swap_regfile #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_regfile (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .raddr0_i(rd_addr),
        .rdata0_o(rd_data),
        .raddr1_i(int_raddr),
        .rdata1_o(int_rdata)
    );

    assign busy    = !idle;
    assign done    = done_q;
    assign cmd_err = cmd_err_q;
    assign wr_rej  = wr_rej_q;

endmodule

// File: tb/tb_swap_ctrl_rf.sv
// Directed bench for swap_ctrl_rf: an 8-entry instance for the command flow
// and a 6-entry instance for address range rejection.
module tb_swap_ctrl_rf;

    logic       clk = 1'b0;
    logic       reset_n;

    logic       start, mode, wr_en;
    logic [2:0] addr_a, addr_b, wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       busy, done, cmd_err, wr_rej;

    logic       s_start, s_mode, s_wr_en;
    logic [2:0] s_addr_a, s_addr_b, s_wr_addr, s_rd_addr;
    logic [7:0] s_wr_data, s_rd_data;
    logic       s_busy, s_done, s_cmd_err, s_wr_rej;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    swap_ctrl_rf #(.WIDTH(8), .DEPTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .addr_a(addr_a), .addr_b(addr_b), .busy(busy), .done(done), .cmd_err(cmd_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rej(wr_rej),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    swap_ctrl_rf #(.WIDTH(8), .DEPTH(6)) u6 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .mode(s_mode),
        .addr_a(s_addr_a), .addr_b(s_addr_b), .busy(s_busy), .done(s_done),
        .cmd_err(s_cmd_err), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .wr_rej(s_wr_rej), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd8(input logic [2:0] a, input logic [7:0] e, input string tag);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic rd6(input logic [2:0] a, input logic [7:0] e, input string tag);
        s_rd_addr = a;
        #1;
        check(tag, 32'(s_rd_data), 32'(e));
    endtask

    task automatic wr8(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic cmd8(input logic m, input logic [2:0] a, input logic [2:0] b);
        start = 1'b1; mode = m; addr_a = a; addr_b = b;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 0; mode = 0; addr_a = 0; addr_b = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_addr = 0;
        s_start = 0; s_mode = 0; s_addr_a = 0; s_addr_b = 0; s_wr_en = 0; s_wr_addr = 0;
        s_wr_data = 0; s_rd_addr = 0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cmd_err", 32'(cmd_err), 0);
        check("rst_wr_rej", 32'(wr_rej), 0);
        reset_n = 1'b1;
        step();

        // 1: swap 2<->5
        wr8(3'd2, 8'hA5);
        wr8(3'd5, 8'h3C);
        cmd8(1'b0, 3'd2, 3'd5);
        step(); start = 0;
        check("swap_busy_t1", 32'(busy), 1);
        check("swap_done_t1", 32'(done), 0);
        step();
        check("swap_busy_t2", 32'(busy), 1);
        step();
        check("swap_busy_t3", 32'(busy), 1);
        step();
        check("swap_busy_t4", 32'(busy), 0);
        check("swap_done_t4", 32'(done), 1);
        step();
        check("swap_done_t5", 32'(done), 0);
        rd8(3'd2, 8'h3C, "swap_m2");
        rd8(3'd5, 8'hA5, "swap_m5");

        // 2: copy 1 -> 6
        wr8(3'd1, 8'h11);
        wr8(3'd6, 8'h66);
        cmd8(1'b1, 3'd1, 3'd6);
        step(); start = 0;
        check("copy_busy_t1", 32'(busy), 1);
        step();
        check("copy_busy_t2", 32'(busy), 1);
        step();
        check("copy_busy_t3", 32'(busy), 0);
        check("copy_done_t3", 32'(done), 1);
        rd8(3'd6, 8'h11, "copy_m6");
        rd8(3'd1, 8'h11, "copy_m1");

        // 3: back-to-back start in done cycle, then start pulses during busy
        step();
        cmd8(1'b0, 3'd2, 3'd3);
        step(); start = 0;
        step(); step(); step();
        check("b2b_done1", 32'(done), 1);
        cmd8(1'b0, 3'd2, 3'd6);
        step();
        check("b2b_accept_busy", 32'(busy), 1);
        cmd8(1'b0, 3'd0, 3'd1);
        step();
        step();
        start = 0;
        step();
        check("b2b_done2", 32'(done), 1);
        step();
        check("b2b_no_extra_done", 32'(done), 0);
        check("b2b_idle", 32'(busy), 0);
        step();
        check("b2b_no_extra_done2", 32'(done), 0);
        rd8(3'd2, 8'h11, "b2b_m2");
        rd8(3'd6, 8'h00, "b2b_m6");
        rd8(3'd3, 8'h3C, "b2b_m3");
        rd8(3'd0, 8'h00, "b2b_m0");
        rd8(3'd1, 8'h11, "b2b_m1");

        // 4: range rejection on a 6-entry instance
        s_wr_en = 1; s_wr_addr = 3'd1; s_wr_data = 8'h77;
        step(); s_wr_en = 0;
        check("d6_wr_ok_no_rej", 32'(s_wr_rej), 0);
        s_start = 1; s_addr_a = 3'd1; s_addr_b = 3'd7;
        step(); s_start = 0;
        check("d6_cmd_err", 32'(s_cmd_err), 1);
        check("d6_busy0", 32'(s_busy), 0);
        step();
        check("d6_cmd_err_pulse", 32'(s_cmd_err), 0);
        check("d6_busy0b", 32'(s_busy), 0);
        s_start = 1; s_addr_a = 3'd6; s_addr_b = 3'd0;
        step(); s_start = 0;
        check("d6_cmd_err_a6", 32'(s_cmd_err), 1);
        s_wr_en = 1; s_wr_addr = 3'd6; s_wr_data = 8'h99;
        step(); s_wr_en = 0;
        check("d6_wr_rej", 32'(s_wr_rej), 1);
        step();
        check("d6_wr_rej_pulse", 32'(s_wr_rej), 0);
        rd6(3'd1, 8'h77, "d6_m1");
        rd6(3'd6, 8'h00, "d6_rd_oor");

        // 5: write during MOVE rejected; write + start together
        step();
        cmd8(1'b0, 3'd3, 3'd4);
        step(); start = 0;
        step();
        wr_en = 1; wr_addr = 3'd7; wr_data = 8'hFF;
        step(); wr_en = 0;
        check("move_wr_rej", 32'(wr_rej), 1);
        step();
        check("move_done", 32'(done), 1);
        check("move_wr_rej_pulse", 32'(wr_rej), 0);
        rd8(3'd7, 8'h00, "move_m7");
        rd8(3'd3, 8'h00, "move_m3");
        rd8(3'd4, 8'h3C, "move_m4");
        step();
        wr_en = 1; wr_addr = 3'd0; wr_data = 8'h5A;
        cmd8(1'b0, 3'd0, 3'd4);
        step(); start = 0; wr_en = 0;
        check("wrst_no_rej", 32'(wr_rej), 0);
        step(); step(); step();
        check("wrst_done", 32'(done), 1);
        rd8(3'd0, 8'h3C, "wrst_m0");
        rd8(3'd4, 8'h5A, "wrst_m4");

        // 6: reset during MOVE
        step();
        cmd8(1'b0, 3'd0, 3'd4);
        step(); start = 0;
        step();
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        rd8(3'd0, 8'h00, "rst_mid_m0");
        rd8(3'd4, 8'h00, "rst_mid_m4");
        rd8(3'd2, 8'h00, "rst_mid_m2");
        step();
        reset_n = 1'b1;
        step();
        check("rst_after_done", 32'(done), 0);
        wr8(3'd0, 8'hC3);
        wr8(3'd4, 8'h3C);
        cmd8(1'b0, 3'd0, 3'd4);
        step(); start = 0;
        step(); step(); step();
        check("post_rst_done", 32'(done), 1);
        rd8(3'd0, 8'h3C, "post_rst_m0");
        rd8(3'd4, 8'hC3, "post_rst_m4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
